// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I-subset core: opcodes, ALU codes,
// FSM states and immediate formats.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXER, EXEI, ALUWB, BEQ, JAL, TRAP
  } state_t;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_t;

  // Only the upper instruction bits carry immediate fields.
  function automatic logic [31:0] imm_ext(input logic [31:7] ins, input imm_t t);
    logic [31:0] v;
    case (t)
      IMM_I:   v = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      default: v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/riscv_multicycle_if.sv
// Unified instruction/data memory port with a req/ready handshake.
interface riscv_multicycle_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/riscv_regfile.sv
// Architectural register file: two combinational reads, one synchronous write, x0 reads 0.
module riscv_regfile #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  localparam int AW = $clog2(NREGS);

  logic [31:0] rf [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (we && wa != 5'd0) begin
      rf[wa[AW-1:0]] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : rf[ra1[AW-1:0]];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : rf[ra2[AW-1:0]];
endmodule

// File: rtl/riscv_multicycle.sv
// Multicycle RV32I-subset core on a single req/ready memory port with sticky trap.
// Optional performance counters are built when RISCV_PERF_CNT_EN is defined.
module riscv_multicycle import riscv_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic                clk,
  input  logic                reset,
  riscv_multicycle_if.master  bus,
  output logic                trap,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instret
);

  state_t      state, dec_next;
  alu_op_t     alu_op, dec_alu;
  logic [31:0] pc, old_pc, ir, alu_out, data_r, a_r, b_r;
  logic        req_r, we_r;
  logic [31:0] addr_r, wdata_r;
  logic [31:0] rf_rd1, rf_rd2, rf_wd;
  logic        rf_we;
  logic        use1, use2, used;

  wire [6:0] opcode = ir[6:0];
  wire [2:0] f3     = ir[14:12];
  wire [6:0] f7     = ir[31:25];

  wire [31:0] imm_i   = imm_ext(ir[31:7], IMM_I);
  wire [31:0] imm_s   = imm_ext(ir[31:7], IMM_S);
  wire [31:0] imm_b   = imm_ext(ir[31:7], IMM_B);
  wire [31:0] imm_j   = imm_ext(ir[31:7], IMM_J);
  wire [31:0] mem_ea  = a_r + ((opcode == OP_SW) ? imm_s : imm_i);
  wire [31:0] jal_tgt = old_pc + imm_j;
  wire        br_bad  = (a_r == b_r) && (alu_out[1:0] != 2'b00);

  assign bus.mem_req   = req_r;
  assign bus.mem_we    = we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    case (op)
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_SLT: return {31'b0, sx < sy};
      default: return x + y;
    endcase
  endfunction

  function automatic logic reg_bad(input logic [4:0] r);
    return {1'b0, r} >= 6'(NREGS);
  endfunction

  // Decode: unsupported encodings and out-of-range register indices all go to TRAP.
  always_comb begin
    dec_next = TRAP;
    dec_alu  = ALU_ADD;
    use1 = 1'b0;
    use2 = 1'b0;
    used = 1'b0;
    case (opcode)
      OP_LW:  if (f3 == 3'b010) begin dec_next = MEMADR; use1 = 1'b1; used = 1'b1; end
      OP_SW:  if (f3 == 3'b010) begin dec_next = MEMADR; use1 = 1'b1; use2 = 1'b1; end
      OP_R: begin
        use1 = 1'b1; use2 = 1'b1; used = 1'b1; dec_next = EXER;
        case ({f7, f3})
          10'b0000000_000: dec_alu = ALU_ADD;
          10'b0100000_000: dec_alu = ALU_SUB;
          10'b0000000_111: dec_alu = ALU_AND;
          10'b0000000_110: dec_alu = ALU_OR;
          10'b0000000_010: dec_alu = ALU_SLT;
          default:         dec_next = TRAP;
        endcase
      end
      OP_I: begin
        use1 = 1'b1; used = 1'b1; dec_next = EXEI;
        case (f3)
          3'b000:  dec_alu = ALU_ADD;
          3'b111:  dec_alu = ALU_AND;
          3'b110:  dec_alu = ALU_OR;
          3'b010:  dec_alu = ALU_SLT;
          default: dec_next = TRAP;
        endcase
      end
      OP_BEQ: if (f3 == 3'b000) begin dec_next = BEQ; use1 = 1'b1; use2 = 1'b1; end
      OP_JAL: begin dec_next = JAL; used = 1'b1; end
      default: ;
    endcase
    if ((use1 && reg_bad(ir[19:15])) || (use2 && reg_bad(ir[24:20])) || (used && reg_bad(ir[11:7])))
      dec_next = TRAP;
  end

  always_comb begin
    rf_we = 1'b0;
    rf_wd = alu_out;
    case (state)
      MEMWB: begin rf_we = 1'b1; rf_wd = data_r; end
      ALUWB: rf_we = 1'b1;
      JAL:   begin rf_we = (jal_tgt[1:0] == 2'b00); rf_wd = old_pc + 32'd4; end
      default: ;
    endcase
  end

  riscv_regfile #(.NREGS(NREGS)) u_rf (
    .clk(clk), .reset(reset),
    .ra1(ir[19:15]), .ra2(ir[24:20]),
    .we(rf_we), .wa(ir[11:7]), .wd(rf_wd),
    .rd1(rf_rd1), .rd2(rf_rd2)
  );

  // Completing states preload the next fetch so a zero-wait fetch costs one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      req_r <= 1'b0;
      we_r  <= 1'b0;
      trap  <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (!req_r) begin
            req_r <= 1'b1; we_r <= 1'b0; addr_r <= pc;
          end else if (bus.mem_ready) begin
            ir     <= bus.mem_rdata;
            old_pc <= pc;
            pc     <= pc + 32'd4;
            req_r  <= 1'b0;
            state  <= DECODE;
          end
        end
        DECODE: begin
          a_r     <= rf_rd1;
          b_r     <= rf_rd2;
          alu_out <= old_pc + imm_b;
          alu_op  <= dec_alu;
          state   <= dec_next;
          if (dec_next == TRAP) trap <= 1'b1;
        end
        MEMADR: begin
          alu_out <= mem_ea;
          if (mem_ea[1:0] != 2'b00) begin
            state <= TRAP; trap <= 1'b1;
          end else begin
            req_r   <= 1'b1;
            addr_r  <= mem_ea;
            we_r    <= (opcode == OP_SW);
            wdata_r <= b_r;
            state   <= (opcode == OP_SW) ? MEMWR : MEMRD;
          end
        end
        MEMRD: if (bus.mem_ready) begin
          data_r <= bus.mem_rdata; req_r <= 1'b0; state <= MEMWB;
        end
        MEMWB: begin req_r <= 1'b1; we_r <= 1'b0; addr_r <= pc; state <= FETCH; end
        MEMWR: if (bus.mem_ready) begin
          we_r <= 1'b0; addr_r <= pc; state <= FETCH;
        end
        EXER:  begin alu_out <= alu(alu_op, a_r, b_r);   state <= ALUWB; end
        EXEI:  begin alu_out <= alu(alu_op, a_r, imm_i); state <= ALUWB; end
        ALUWB: begin req_r <= 1'b1; we_r <= 1'b0; addr_r <= pc; state <= FETCH; end
        BEQ: begin
          if (br_bad) begin
            state <= TRAP; trap <= 1'b1;
          end else begin
            req_r <= 1'b1; we_r <= 1'b0; state <= FETCH;
            if (a_r == b_r) begin pc <= alu_out; addr_r <= alu_out; end
            else addr_r <= pc;
          end
        end
        JAL: begin
          if (jal_tgt[1:0] != 2'b00) begin
            state <= TRAP; trap <= 1'b1;
          end else begin
            pc <= jal_tgt; req_r <= 1'b1; we_r <= 1'b0; addr_r <= jal_tgt; state <= FETCH;
          end
        end
        TRAP:    req_r <= 1'b0;
        default: begin state <= TRAP; trap <= 1'b1; req_r <= 1'b0; end
      endcase
    end
  end

`ifdef RISCV_PERF_CNT_EN
  logic retire;
  assign retire = (state == MEMWB) || (state == ALUWB) ||
                  (state == MEMWR && bus.mem_ready) ||
                  (state == BEQ && !br_bad) ||
                  (state == JAL && jal_tgt[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      if (state != TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire)        instret   <= instret + 32'd1;
    end
  end
`else
  assign cycle_cnt = 32'h0;
  assign instret   = 32'h0;
`endif

endmodule
